// File: rtl/jpeg_bitstream_unstuffer.sv
// JPEG entropy-segment unstuffer: drops 0xFF00 stuffing and 0xFF fill bytes, halts on markers,
// and presents a left-justified MSB-first 16-bit window. Define JPEG_UNSTUFF_RST_EN to absorb RSTm markers.
module jpeg_bitstream_unstuffer #(
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] win_data,
  output logic [6:0]  win_bits,
  input  logic        consume,
  input  logic [4:0]  consume_len,
  output logic        marker_valid,
  output logic [7:0]  marker_code,
  input  logic        marker_ack,
  output logic        rst_seen,
  output logic        error
);
  typedef enum logic [1:0] {
    DATA    = 2'd0,
    FF_SEEN = 2'd1,
    MARKER  = 2'd2
`ifdef JPEG_UNSTUFF_RST_EN
    , RST_WAIT = 2'd3
`endif
  } state_t;

  localparam logic [6:0] READY_LIM = 7'(ACC_W - 8);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next, acc_cons;
  logic [6:0]       fill_reg, fill_next, fill_cons, len_ext;
  logic [7:0]       code_reg, code_next, append_byte;
  logic             error_reg, error_next;
  logic             ready_reg, ready_next;
  logic             mv_reg, mv_next;
  logic             rs_reg, rs_next;
  logic [15:0]      win_data_reg, win_data_next;
  logic [6:0]       win_bits_reg, win_bits_next;
  logic             accept, do_consume, bad_len, append;

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    fill_next   = fill_reg;
    code_next   = code_reg;
    error_next  = error_reg;
    rs_next     = 1'b0;
    append      = 1'b0;
    append_byte = in_data;
    accept      = in_valid && ready_reg;
    len_ext     = {2'b00, consume_len};
    do_consume  = consume && !(state_reg == MARKER && marker_ack);
    bad_len     = (consume_len == 5'd0) || (consume_len > 5'd16) || (len_ext > win_bits_reg);
    acc_cons    = acc_reg;
    fill_cons   = fill_reg;

    // Over-consuming the buffered bits (legal only in MARKER) just empties the accumulator.
    if (do_consume) begin
      if (bad_len) begin
        error_next = 1'b1;
        acc_cons   = '0;
        fill_cons  = '0;
      end else if (len_ext >= fill_reg) begin
        acc_cons  = '0;
        fill_cons = '0;
      end else begin
        acc_cons  = acc_reg << consume_len;
        fill_cons = fill_reg - len_ext;
      end
    end

    if (accept) begin
      case (state_reg)
        FF_SEEN: begin
          if (in_data == 8'h00) begin
            append      = 1'b1;
            append_byte = 8'hFF;
            state_next  = DATA;
          end else if (in_data == 8'hFF) begin
            state_next = FF_SEEN;
`ifdef JPEG_UNSTUFF_RST_EN
          end else if (in_data[7:3] == 5'b11010) begin
            state_next = RST_WAIT;
`endif
          end else begin
            code_next  = in_data;
            state_next = MARKER;
          end
        end
        default: begin
          if (in_data == 8'hFF) state_next = FF_SEEN;
          else                  append     = 1'b1;
        end
      endcase
    end

    // New byte lands directly behind whatever survives this cycle's consume.
    if (append) begin
      acc_next  = acc_cons | ({append_byte, {(ACC_W-8){1'b0}}} >> fill_cons);
      fill_next = fill_cons + 7'd8;
    end else begin
      acc_next  = acc_cons;
      fill_next = fill_cons;
    end

    if (state_reg == MARKER && marker_ack) begin
      state_next = DATA;
      acc_next   = '0;
      fill_next  = '0;
    end
`ifdef JPEG_UNSTUFF_RST_EN
    if (state_reg == RST_WAIT && fill_reg < 7'd8) begin
      state_next = DATA;
      acc_next   = '0;
      fill_next  = '0;
      rs_next    = 1'b1;
    end
`endif
    if (flush) begin
      state_next = DATA;
      acc_next   = '0;
      fill_next  = '0;
      code_next  = '0;
      error_next = 1'b0;
      rs_next    = 1'b0;
    end

    ready_next    = (state_next == DATA || state_next == FF_SEEN) && (fill_next <= READY_LIM);
    mv_next       = (state_next == MARKER);
    win_bits_next = (mv_next && fill_next < 7'd16) ? 7'd16 : fill_next;
    win_data_next = acc_next[ACC_W-1 -: 16] |
                    ((fill_next >= 7'd16) ? 16'h0000 : (16'hFFFF >> fill_next));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= DATA;
      acc_reg      <= '0;
      fill_reg     <= '0;
      code_reg     <= '0;
      error_reg    <= 1'b0;
      ready_reg    <= 1'b0;
      mv_reg       <= 1'b0;
      rs_reg       <= 1'b0;
      win_data_reg <= 16'hFFFF;
      win_bits_reg <= '0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      fill_reg     <= fill_next;
      code_reg     <= code_next;
      error_reg    <= error_next;
      ready_reg    <= ready_next;
      mv_reg       <= mv_next;
      rs_reg       <= rs_next;
      win_data_reg <= win_data_next;
      win_bits_reg <= win_bits_next;
    end
  end

  assign in_ready     = ready_reg;
  assign win_data     = win_data_reg;
  assign win_bits     = win_bits_reg;
  assign marker_valid = mv_reg;
  assign marker_code  = code_reg;
  assign rst_seen     = rs_reg;
  assign error        = error_reg;
endmodule

// File: tb/tb_jpeg_bitstream_unstuffer.sv
// Bench for jpeg_bitstream_unstuffer: bit-queue reference model checked every cycle,
// directed literal cases, then randomized byte stream with random consumes/acks/flushes.
module tb_jpeg_bitstream_unstuffer;
  localparam int ACC_W = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] win_data;
  logic [6:0]  win_bits;
  logic        consume = 1'b0;
  logic [4:0]  consume_len = 5'd0;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack = 1'b0;
  logic        rst_seen;
  logic        error;

  always #5 clk = ~clk;

  jpeg_bitstream_unstuffer #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .win_data(win_data), .win_bits(win_bits), .consume(consume),
    .consume_len(consume_len), .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_ack(marker_ack), .rst_seen(rst_seen), .error(error)
  );

  typedef enum {M_DATA, M_FF, M_MARKER, M_RSTW} mstate_t;
  mstate_t    mst = M_DATA;
  bit         q[$];
  logic [7:0] m_code = 8'h00;
  bit         m_err = 0, m_rs = 0, m_post = 0, m_acc = 0;
  int         checks = 0, failures = 0;

  function automatic bit m_ready();
    return m_post && (mst == M_DATA || mst == M_FF) && q.size() <= ACC_W - 8;
  endfunction

  function automatic int m_bits();
    if (mst == M_MARKER && q.size() < 16) return 16;
    return q.size();
  endfunction

  function automatic logic [15:0] m_win();
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = (i < q.size()) ? q[i] : 1'b1;
    return w;
  endfunction

  task automatic m_clear();
    q.delete(); mst = M_DATA; m_code = 8'h00; m_err = 0; m_rs = 0;
  endtask

  task automatic m_push(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) q.push_back(b[i]);
  endtask

  // One clock of the reference: ack/consume on the old bits, then the accepted byte.
  task automatic model_update();
    bit rdy;
    int pre_size;
    mstate_t pre_st;
    m_acc = 0;
    if (!rst_n) begin m_clear(); m_post = 0; return; end
    rdy = m_ready(); pre_size = q.size(); pre_st = mst;
    m_post = 1; m_rs = 0;
    if (flush) begin m_clear(); return; end
    if (mst == M_MARKER && marker_ack) begin
      q.delete(); mst = M_DATA;
    end else if (consume) begin
      if (consume_len == 0 || consume_len > 16 || int'(consume_len) > m_bits()) begin
        m_err = 1; q.delete();
      end else begin
        for (int i = 0; i < int'(consume_len); i++) if (q.size() > 0) void'(q.pop_front());
      end
    end
    if (in_valid && rdy) begin
      m_acc = 1;
      if (mst == M_DATA) begin
        if (in_data == 8'hFF) mst = M_FF; else m_push(in_data);
      end else begin
        if (in_data == 8'h00) begin m_push(8'hFF); mst = M_DATA; end
        else if (in_data == 8'hFF) begin end
`ifdef JPEG_UNSTUFF_RST_EN
        else if (in_data >= 8'hD0 && in_data <= 8'hD7) mst = M_RSTW;
`endif
        else begin m_code = in_data; mst = M_MARKER; end
      end
    end
    if (pre_st == M_RSTW && pre_size < 8) begin q.delete(); mst = M_DATA; m_rs = 1; end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 16'(in_ready), 16'(m_ready()));
    chk("win_data", win_data, m_win());
    chk("win_bits", 16'(win_bits), 16'(m_bits()));
    chk("marker_valid", 16'(marker_valid), 16'(mst == M_MARKER));
    chk("marker_code", 16'(marker_code), 16'(m_code));
    chk("rst_seen", 16'(rst_seen), 16'(m_rs));
    chk("error", 16'(error), 16'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; in_data = b;
    step(); n++;
    while (!m_acc && n < 40) begin step(); n++; end
    in_valid = 1'b0;
    if (!m_acc) begin
      checks++; failures++;
      $display("FAIL send_timeout: byte %h not accepted in %0d cycles", b, n);
    end
  endtask

  task automatic cons(input int len);
    consume = 1'b1; consume_len = 5'(len);
    step();
    consume = 1'b0;
  endtask

  task automatic ack();
    marker_ack = 1'b1; step(); marker_ack = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); flush = 1'b0;
  endtask

  function automatic logic [7:0] gen();
    int r;
    r = $urandom % 10;
    if (r < 2) return 8'hFF;
    if (r == 2) return 8'h00;
    return 8'($urandom);
  endfunction

  initial begin
    logic [7:0] cur;
    bit saw;
    int n, b;

    repeat (2) @(negedge clk);
    check_all();
    chk("rst_ready", 16'(in_ready), 16'h0000);
    chk("rst_win", win_data, 16'hFFFF);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 16'(in_ready), 16'h0001);

    // plain bytes then a partial consume
    send(8'hA5); send(8'h3C);
    chk("t1_bits", 16'(win_bits), 16'd16);
    chk("t1_data", win_data, 16'hA53C);
    cons(4);
    chk("t1c_bits", 16'(win_bits), 16'd12);
    chk("t1c_data", win_data, 16'h53CF);

    // stuffing byte removed
    do_flush();
    send(8'hFF); send(8'h00); send(8'h12);
    chk("t2_bits", 16'(win_bits), 16'd16);
    chk("t2_data", win_data, 16'hFF12);

    // fill bytes then marker
    do_flush();
    send(8'h80); send(8'hFF); send(8'hFF); send(8'hFF); send(8'hD9);
    chk("t3_mv", 16'(marker_valid), 16'h0001);
    chk("t3_code", 16'(marker_code), 16'h00D9);
    chk("t3_ready", 16'(in_ready), 16'h0000);
    chk("t3_bits", 16'(win_bits), 16'd16);
    chk("t3_data", win_data, 16'h80FF);
    cons(16);
    chk("t3_noerr", 16'(error), 16'h0000);
    chk("t3_pad", win_data, 16'hFFFF);
    ack();
    chk("t3_ack_bits", 16'(win_bits), 16'd0);
    chk("t3_ack_ready", 16'(in_ready), 16'h0001);
    chk("t3_ack_mv", 16'(marker_valid), 16'h0000);

    // restart marker
    do_flush();
    send(8'h5F); send(8'hFF); send(8'hD3);
`ifdef JPEG_UNSTUFF_RST_EN
    chk("t4_ready", 16'(in_ready), 16'h0000);
    cons(3);
    chk("t4_bits5", 16'(win_bits), 16'd5);
    saw = 0; n = 0;
    in_valid = 1'b1; in_data = 8'h40;
    m_acc = 0;
    while (!m_acc && n < 10) begin
      step(); n++;
      if (rst_seen === 1'b1) saw = 1;
    end
    in_valid = 1'b0;
    chk("t4_rst_pulse", 16'(saw), 16'h0001);
    chk("t4_data", win_data, 16'h40FF);
    chk("t4_bits", 16'(win_bits), 16'd8);
`else
    chk("t4_mv", 16'(marker_valid), 16'h0001);
    chk("t4_code", 16'(marker_code), 16'h00D3);
    ack();
`endif

    // full accumulator, consume with a pending byte
    do_flush();
    for (int i = 0; i < ACC_W / 8; i++) send(8'((i + 1) * 8'h11));
    chk("t5_full_ready", 16'(in_ready), 16'h0000);
    chk("t5_full_bits", 16'(win_bits), 16'(ACC_W));
    chk("t5_full_data", win_data, 16'h1122);
    in_valid = 1'b1; in_data = 8'h99; consume = 1'b1; consume_len = 5'd8;
    step();
    chk("t5_c1_bits", 16'(win_bits), 16'(ACC_W - 8));
    chk("t5_c1_ready", 16'(in_ready), 16'h0001);
    step();
    in_valid = 1'b0; consume = 1'b0;
    chk("t5_c2_bits", 16'(win_bits), 16'(ACC_W - 8));
    chk("t5_c2_data", win_data, 16'h3344);
    cons(16);
    chk("t5_tail", win_data, 16'h99FF);

    // illegal consume, then async reset mid-MARKER
    do_flush();
    send(8'h5A);
    cons(9);
    chk("t6_err", 16'(error), 16'h0001);
    chk("t6_bits", 16'(win_bits), 16'd0);
    send(8'hFF); send(8'hD9);
    chk("t6_mv", 16'(marker_valid), 16'h0001);
    rst_n = 1'b0;
    #1;
    m_clear(); m_post = 0;
    chk("t6r_ready", 16'(in_ready), 16'h0000);
    chk("t6r_data", win_data, 16'hFFFF);
    chk("t6r_bits", 16'(win_bits), 16'd0);
    chk("t6r_mv", 16'(marker_valid), 16'h0000);
    chk("t6r_code", 16'(marker_code), 16'h0000);
    chk("t6r_rs", 16'(rst_seen), 16'h0000);
    chk("t6r_err", 16'(error), 16'h0000);
    step();
    rst_n = 1'b1;
    #1;
    check_all();
    step();
    chk("t6_ready_after", 16'(in_ready), 16'h0001);

    // randomized stream
    do_flush();
    cur = gen();
    for (int c = 0; c < 4000; c++) begin
      in_valid = ($urandom % 4 != 0);
      in_data = cur;
      consume = 1'b0; marker_ack = 1'b0; flush = 1'b0;
      if (mst == M_MARKER && $urandom % 3 == 0) marker_ack = 1'b1;
      b = m_bits();
      if (b > 0 && $urandom % 3 != 0) begin
        consume = 1'b1;
        consume_len = 5'($urandom_range(1, (b > 16) ? 16 : b));
      end
      if ($urandom % 400 == 0) begin
        consume = 1'b1; in_valid = 1'b0; marker_ack = 1'b0;
        consume_len = (b < 16) ? 5'(b + 1) : 5'd0;
      end
      if ($urandom % 700 == 0) flush = 1'b1;
      step();
      if (m_acc) cur = gen();
    end
    in_valid = 1'b0; consume = 1'b0; marker_ack = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
